// File: rtl/rename_stage.sv
// Register rename stage: 32-entry RAT, circular free list of physical tags and
// a per-tag ready vector fed by the CDB; renamed results are registered.
module rename_stage #(
    parameter int PHYS_REGS = 64,
    parameter int PREG_W    = $clog2(PHYS_REGS),
    parameter int FL_DEPTH  = PHYS_REGS - 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              inst_valid_i,
    input  logic [4:0]        rs1_addr_i,
    input  logic [4:0]        rs2_addr_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              rd_we_i,
    output logic              ready_o,
    input  logic              cdb_en_i,
    input  logic [PREG_W-1:0] cdb_preg_i,
    input  logic              commit_en_i,
    input  logic [PREG_W-1:0] commit_free_preg_i,
    output logic              out_valid_o,
    output logic [PREG_W-1:0] prs1_addr_o,
    output logic [PREG_W-1:0] prs2_addr_o,
    output logic [PREG_W-1:0] prd_addr_o,
    output logic [PREG_W-1:0] old_prd_addr_o,
    output logic              prs1_rdy_o,
    output logic              prs2_rdy_o
);

    localparam int FL_W  = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam int CNT_W = $clog2(FL_DEPTH + 1);

    logic [PREG_W-1:0]    rat_q [32];
    logic [PREG_W-1:0]    fl_q  [FL_DEPTH];
    logic [PHYS_REGS-1:0] rdy_q;
    logic [FL_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic              out_valid_q, prs1_rdy_q, prs2_rdy_q;
    logic [PREG_W-1:0] prs1_q, prs2_q, prd_q, old_prd_q;

    logic              accept, alloc, push;
    logic [PREG_W-1:0] src1_tag, src2_tag, alloc_tag;
    logic              src1_rdy, src2_rdy;

    assign ready_o = (count_q != '0);

    always_comb begin
        accept    = inst_valid_i && ready_o;
        alloc     = accept && rd_we_i && (rd_addr_i != '0);
        push      = commit_en_i && (commit_free_preg_i != '0) && (count_q != CNT_W'(FL_DEPTH));
        src1_tag  = rat_q[rs1_addr_i];
        src2_tag  = rat_q[rs2_addr_i];
        // Same-cycle CDB write-back counts as ready for the source being renamed.
        src1_rdy  = rdy_q[src1_tag] || (cdb_en_i && (cdb_preg_i == src1_tag));
        src2_rdy  = rdy_q[src2_tag] || (cdb_en_i && (cdb_preg_i == src2_tag));
        alloc_tag = fl_q[head_q];

        head_d = head_q;
        if (alloc)
            head_d = (head_q == FL_W'(FL_DEPTH - 1)) ? '0 : head_q + 1'b1;
        tail_d = tail_q;
        if (push)
            tail_d = (tail_q == FL_W'(FL_DEPTH - 1)) ? '0 : tail_q + 1'b1;

        count_d = count_q;
        case ({push, alloc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < 32; i++)
                rat_q[i] <= PREG_W'(i);
            for (int unsigned i = 0; i < FL_DEPTH; i++)
                fl_q[i] <= PREG_W'(32 + i);
            rdy_q       <= '1;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= CNT_W'(FL_DEPTH);
            out_valid_q <= 1'b0;
            prs1_q      <= '0;
            prs2_q      <= '0;
            prd_q       <= '0;
            old_prd_q   <= '0;
            prs1_rdy_q  <= 1'b0;
            prs2_rdy_q  <= 1'b0;
        end else begin
            // Allocation clear is ordered after the CDB set so it takes priority.
            if (cdb_en_i)
                rdy_q[cdb_preg_i] <= 1'b1;
            if (alloc) begin
                rdy_q[alloc_tag]  <= 1'b0;
                rat_q[rd_addr_i]  <= alloc_tag;
            end
            if (push)
                fl_q[tail_q] <= commit_free_preg_i;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= accept;
            if (accept) begin
                prs1_q     <= src1_tag;
                prs2_q     <= src2_tag;
                prs1_rdy_q <= src1_rdy;
                prs2_rdy_q <= src2_rdy;
                prd_q      <= alloc ? alloc_tag : '0;
                old_prd_q  <= alloc ? rat_q[rd_addr_i] : '0;
            end
        end
    end

    assign out_valid_o    = out_valid_q;
    assign prs1_addr_o    = prs1_q;
    assign prs2_addr_o    = prs2_q;
    assign prd_addr_o     = prd_q;
    assign old_prd_addr_o = old_prd_q;
    assign prs1_rdy_o     = prs1_rdy_q;
    assign prs2_rdy_o     = prs2_rdy_q;

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: directed scenarios plus random traffic, every cycle
// compared against a queue/array model of the rename rules.
module tb_rename_stage;

    localparam int PR  = 64;
    localparam int PW  = 6;
    localparam int FLD = PR - 32;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0, inst_valid_i = 1'b0, rd_we_i = 1'b0;
    logic [4:0]    rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
    logic          cdb_en_i = 1'b0, commit_en_i = 1'b0;
    logic [PW-1:0] cdb_preg_i = '0, commit_free_preg_i = '0;
    logic          ready_o, out_valid_o, prs1_rdy_o, prs2_rdy_o;
    logic [PW-1:0] prs1_addr_o, prs2_addr_o, prd_addr_o, old_prd_addr_o;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int rat_m [32];
    bit rdy_m [PR];
    int fl_m [$];
    int e_valid, e_p1, e_p2, e_pd, e_old, e_r1, e_r2;

    always #5 clk = ~clk;

    rename_stage #(.PHYS_REGS(PR)) dut (
        .clk_i(clk), .reset_i(reset_i), .inst_valid_i(inst_valid_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .rd_we_i(rd_we_i), .ready_o(ready_o), .cdb_en_i(cdb_en_i),
        .cdb_preg_i(cdb_preg_i), .commit_en_i(commit_en_i),
        .commit_free_preg_i(commit_free_preg_i), .out_valid_o(out_valid_o),
        .prs1_addr_o(prs1_addr_o), .prs2_addr_o(prs2_addr_o),
        .prd_addr_o(prd_addr_o), .old_prd_addr_o(old_prd_addr_o),
        .prs1_rdy_o(prs1_rdy_o), .prs2_rdy_o(prs2_rdy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then check all outputs.
    task automatic step(input bit rst, input bit iv, input int rs1, input int rs2,
                        input int rd, input bit we, input bit ce, input int cp,
                        input bit cm, input int fp);
        int  n;
        bit  acc, al;
        reset_i = rst; inst_valid_i = iv; rs1_addr_i = 5'(rs1); rs2_addr_i = 5'(rs2);
        rd_addr_i = 5'(rd); rd_we_i = we; cdb_en_i = ce; cdb_preg_i = PW'(cp);
        commit_en_i = cm; commit_free_preg_i = PW'(fp);
        if (rst) begin
            for (int i = 0; i < 32; i++) rat_m[i] = i;
            for (int i = 0; i < PR; i++) rdy_m[i] = 1'b1;
            fl_m.delete();
            for (int i = 32; i < PR; i++) fl_m.push_back(i);
            e_valid = 0; e_p1 = 0; e_p2 = 0; e_pd = 0; e_old = 0; e_r1 = 0; e_r2 = 0;
        end else begin
            n   = fl_m.size();
            acc = iv && (n != 0);
            al  = acc && we && (rd != 0);
            e_valid = acc;
            if (acc) begin
                e_p1 = rat_m[rs1];
                e_p2 = rat_m[rs2];
                e_r1 = (rdy_m[e_p1] || (ce && cp == e_p1)) ? 1 : 0;
                e_r2 = (rdy_m[e_p2] || (ce && cp == e_p2)) ? 1 : 0;
                e_pd = 0; e_old = 0;
                if (al) begin
                    e_pd = fl_m.pop_front();
                    e_old = rat_m[rd];
                    rat_m[rd] = e_pd;
                end
            end
            if (ce) rdy_m[cp] = 1'b1;
            if (al) rdy_m[e_pd] = 1'b0;
            if (cm && fp != 0 && n != FLD) fl_m.push_back(fp);
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid_o, e_valid);
        chk("ready", ready_o, (fl_m.size() != 0) ? 1 : 0);
        chk("prs1", prs1_addr_o, e_p1);
        chk("prs2", prs2_addr_o, e_p2);
        chk("prd", prd_addr_o, e_pd);
        chk("old_prd", old_prd_addr_o, e_old);
        chk("prs1_rdy", prs1_rdy_o, e_r1);
        chk("prs2_rdy", prs2_rdy_o, e_r2);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_prd", prd_addr_o, 0);

        // Commit while full is dropped; rd=0 allocates nothing
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 40);
        step(0, 1, 1, 2, 0, 1, 0, 0, 0, 0);
        chk("rd0_valid", out_valid_o, 1);
        chk("rd0_prd", prd_addr_o, 0);
        chk("rd0_old", old_prd_addr_o, 0);

        // First rename
        step(0, 1, 1, 2, 3, 1, 0, 0, 0, 0);
        chk("r031_prs1", prs1_addr_o, 1);
        chk("r031_prs2", prs2_addr_o, 2);
        chk("r031_prd", prd_addr_o, 32);
        chk("r031_old", old_prd_addr_o, 3);
        chk("r031_rdy1", prs1_rdy_o, 1);
        chk("r031_rdy2", prs2_rdy_o, 1);

        // Dependent source, then CDB bypass
        step(0, 1, 3, 0, 4, 1, 0, 0, 0, 0);
        chk("r032_prs1", prs1_addr_o, 32);
        chk("r032_rdy1", prs1_rdy_o, 0);
        step(0, 1, 3, 0, 5, 1, 1, 32, 0, 0);
        chk("r032_byp_rdy1", prs1_rdy_o, 1);
        chk("r032_byp_prd", prd_addr_o, 34);

        // rs==rd sees the old mapping
        step(0, 1, 5, 5, 5, 1, 0, 0, 0, 0);
        chk("r027_prs1", prs1_addr_o, 34);
        chk("r027_old", old_prd_addr_o, 34);
        chk("r027_prd", prd_addr_o, 35);

        // Drain the remaining 28 tags
        for (int i = 0; i < 28; i++)
            step(0, 1, $urandom_range(0, 31), $urandom_range(0, 31), (i % 31) + 1, 1, 0, 0, 0, 0);
        chk("drain_ready", ready_o, 0);
        step(0, 1, 1, 2, 7, 1, 0, 0, 0, 0);
        chk("empty_no_valid", out_valid_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("commit0_ready", ready_o, 0);

        // Commit refills an empty list
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        chk("commit5_ready", ready_o, 1);
        step(0, 1, 0, 0, 8, 1, 0, 0, 0, 0);
        chk("commit5_prd", prd_addr_o, 5);
        chk("commit5_empty", ready_o, 0);

        // Push and pop together at free_count=1
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        step(0, 1, 0, 0, 9, 1, 0, 0, 1, 7);
        chk("r034_prd", prd_addr_o, 9);
        chk("r034_ready", ready_o, 1);
        step(0, 1, 0, 0, 10, 1, 0, 0, 0, 0);
        chk("r034_next", prd_addr_o, 7);
        chk("r034_empty", ready_o, 0);

        // Reset mid-operation overrides concurrent traffic
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, 1, 0, 0, i + 1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 3, 1, 1, 33, 1, 12);
        chk("r036_valid", out_valid_o, 0);
        step(0, 1, 3, 10, 3, 1, 0, 0, 0, 0);
        chk("r036_prs1", prs1_addr_o, 3);
        chk("r036_prs2", prs2_addr_o, 10);
        chk("r036_prd", prd_addr_o, 32);
        chk("r036_old", old_prd_addr_o, 3);

        // Random traffic against the model
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 1), ($urandom_range(0, 2) == 0), $urandom_range(0, PR - 1),
                 ($urandom_range(0, 4) < 2), $urandom_range(0, PR - 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 Parameter PHYS_REGS, default 64, number of physical registers; SHALL be a power of two greater than 32.
REQ-002 Parameter PREG_W, default $clog2(PHYS_REGS), physical register tag width.
REQ-003 Parameter FL_DEPTH, default PHYS_REGS-32, free-list capacity.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 inst_valid_i  in  1  decoded instruction present.
REQ-007 rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  architectural source/destination registers.
REQ-008 rd_we_i  in  1  instruction writes rd.
REQ-009 ready_o  out  1  stage can accept an instruction this cycle.
REQ-010 cdb_en_i  in  1  CDB broadcast valid; cdb_preg_i  in  PREG_W  tag being written back.
REQ-011 commit_en_i  in  1  retirement frees a tag; commit_free_preg_i  in  PREG_W  tag returned to the free list.
REQ-012 out_valid_o  out  1  renamed instruction valid, one-cycle pulse.
REQ-013 prs1_addr_o, prs2_addr_o, prd_addr_o, old_prd_addr_o  out  PREG_W each  renamed tags plus the prior rd mapping.
REQ-014 prs1_rdy_o, prs2_rdy_o  out  1 each  source value already available.

Function
REQ-015 Accept = inst_valid_i && ready_o; ready_o SHALL equal (free_count != 0), registered-state-only, with no combinational path from any input.
REQ-016 Outputs SHALL be registered: latency one cycle from accept to out_valid_o=1; out_valid_o=0 in any cycle following a non-accept.
REQ-017 RAT: 32 entries x PREG_W; sources SHALL read the RAT state before this cycle's update.
REQ-018 Allocation occurs iff accept && rd_we_i && rd_addr_i!=0: pop free-list head into prd_addr_o, set RAT[rd]=popped tag, clear its ready bit, drive old_prd_addr_o = previous RAT[rd].
REQ-019 No allocation (rd_we_i=0 or rd=0): prd_addr_o=0, old_prd_addr_o=0, free list and RAT unchanged.
REQ-020 Architectural x0 SHALL always map to tag 0, ready=1; tag 0 SHALL never be allocated or freed.
REQ-021 Ready bits: PHYS_REGS-entry vector; cdb_en_i sets bit[cdb_preg_i]; allocation clears bit of allocated tag.
REQ-022 CDB bypass: if cdb_en_i && cdb_preg_i equals a source's mapped tag in the accept cycle, that source's rdy output SHALL be 1.
REQ-023 Free list: circular FIFO of FL_DEPTH entries, head/tail pointers wrap modulo FL_DEPTH, free_count 0..FL_DEPTH.
REQ-024 commit_en_i pushes commit_free_preg_i at tail; tag 0 and push while free_count==FL_DEPTH SHALL be ignored (no state change).
REQ-025 Simultaneous push and pop: both performed, free_count unchanged.
REQ-026 Empty list: ready_o=0; a commit in that cycle makes ready_o=1 next cycle; inst_valid_i while ready_o=0 SHALL be ignored.
REQ-027 Source rename and destination allocation in the same instruction with rs==rd SHALL return the old mapping for the source.

Reset
REQ-028 On reset_i=1 at a clock edge: RAT[i]=i for all i; free list holds tags 32..PHYS_REGS-1 in ascending order, head=0, tail=0, free_count=FL_DEPTH; ready bits all 1.
REQ-029 Reset outputs: out_valid_o=0, all tag outputs 0, rdy outputs 0, ready_o=1 the cycle after reset deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight state and override simultaneous accept, CDB and commit in that cycle.

Verification
REQ-031 After reset, rename rs1=1,rs2=2,rd=3,rd_we=1 -> next cycle out_valid_o=1, prs1=1, prs2=2, prd=32, old_prd=3, both rdy=1.
REQ-032 Back-to-back: rd=3 then rs1=3 -> second result prs1=32, prs1_rdy=0; with cdb_en_i=1, cdb_preg_i=32 in the second accept cycle -> prs1_rdy=1.
REQ-033 Thirty-two allocations, no commits -> ready_o=0 after the 32nd; a 33rd valid instruction produces no out_valid_o; one commit of tag 5 -> ready_o=1 next cycle; the next allocation returns prd=5.
REQ-034 Commit of tag 7 and allocation in the same cycle with free_count=1 -> allocation returns the head tag, free_count stays 1, and tag 7 is returned by the following allocation.
REQ-035 rd=0 with rd_we=1 -> prd=0, free_count unchanged; commit of tag 0 or commit while full -> free_count unchanged.
REQ-036 Reset asserted after 10 allocations -> RAT identity, free_count=32, next allocation returns prd=32.
